// File: rtl/ddr_ca_dly_pkg.sv
// ddr_ca_dly_pkg: shared types and constants for the CA/CS delay lane controller
package ddr_ca_dly_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, LOAD, DONE} state_t;
  typedef enum logic [1:0] {OP_UP = 2'b00, OP_DOWN = 2'b01, OP_LOAD = 2'b10, OP_ILLEGAL = 2'b11} op_t;
  localparam logic [3:0] IDLE_PAT = 4'b1111;
  localparam int STATS_W = 16;
endpackage

// File: rtl/ddr_ca_dly_tap_tracker.sv
// ddr_ca_dly_tap_tracker: per-lane tap position registers with inc/dec/load and bound flags
// Ports: clk/rst (async active-high), sel one-hot lane, inc/dec/load strobes,
// tap_value packed per-lane taps, at_max/at_min per-lane bound flags.
module ddr_ca_dly_tap_tracker #(
  parameter int NUM_LANES = 8,
  parameter int TAP_W = 7,
  parameter int TAP_MAX = 127,
  parameter int TAP_DEFAULT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       sel,
  input  logic                       inc,
  input  logic                       dec,
  input  logic                       load,
  output logic [NUM_LANES*TAP_W-1:0] tap_value,
  output logic [NUM_LANES-1:0]       at_max,
  output logic [NUM_LANES-1:0]       at_min
);
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [TAP_W-1:0] q;
    // the bounds also clamp here so the tracked tap can never wrap
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= TAP_W'(TAP_DEFAULT);
      else if (sel[i] && load) q <= TAP_W'(TAP_DEFAULT);
      else if (sel[i] && inc && !at_max[i]) q <= q + 1'b1;
      else if (sel[i] && dec && !at_min[i]) q <= q - 1'b1;
    assign at_max[i] = q == TAP_W'(TAP_MAX);
    assign at_min[i] = q == '0;
    assign tap_value[i*TAP_W +: TAP_W] = q;
  end
endmodule

// File: rtl/ddr_ca_dly_lane_ctrl.sv
// ddr_ca_dly_lane_ctrl: multi-lane DDR3 CA/CS IOD delay-line controller and 4:1 TX/OE register stage
// Ports: fab_clk/arst (async active-high); req_* request handshake (lane, op, steps);
// rsp_* one-cycle completion; lane_busy/tap_value status; dl_* IOD delay-line controls;
// fab_tx_data/fab_oe_data in, tx_data/oe_data registered out (busy lane forced idle high).
// Optional: DDR_CA_DLY_STATS_EN adds err_count, a saturating count of error responses.
module ddr_ca_dly_lane_ctrl
  import ddr_ca_dly_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int TAP_W = 7,
  parameter int TAP_MAX = 127,
  parameter int TAP_DEFAULT = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       fab_clk,
  input  logic                       arst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LANE_W-1:0]          req_lane,
  input  logic [1:0]                 req_op,
  input  logic [TAP_W-1:0]           req_steps,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [TAP_W-1:0]           rsp_tap,
`ifdef DDR_CA_DLY_STATS_EN
  output logic [STATS_W-1:0]         err_count,
`endif
  output logic [NUM_LANES-1:0]       lane_busy,
  output logic [NUM_LANES*TAP_W-1:0] tap_value,
  output logic [NUM_LANES-1:0]       dl_move,
  output logic [NUM_LANES-1:0]       dl_direction,
  output logic [NUM_LANES-1:0]       dl_load,
  input  logic [NUM_LANES-1:0]       dl_out_of_range,
  input  logic [NUM_LANES*4-1:0]     fab_tx_data,
  input  logic [NUM_LANES*4-1:0]     fab_oe_data,
  output logic [NUM_LANES*4-1:0]     tx_data,
  output logic [NUM_LANES*4-1:0]     oe_data
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SPAN = 1 << LANE_W;
  // lane indices the request field can encode but that do not exist map to 0
  localparam logic [SPAN-1:0] LANE_OK = {SPAN{1'b1}} >> (SPAN - NUM_LANES);
  state_t state;
  op_t op_q;
  logic [LANE_W-1:0] lane_q;
  logic [TAP_W-1:0] steps_q;
  logic [CNT_W-1:0] cnt;
  logic [NUM_LANES-1:0] req_oh, lane_oh, at_max, at_min;
  logic [TAP_W-1:0] taps [NUM_LANES];
  logic [TAP_W-1:0] tap_sel;
  logic [NUM_LANES*4-1:0] tx_q, oe_q;
  logic legal, blocked, oor;
  assign req_ready = state == IDLE;
  assign req_oh = NUM_LANES'(1) << req_lane;
  assign lane_oh = NUM_LANES'(1) << lane_q;
  assign legal = LANE_OK[req_lane] && req_op != OP_ILLEGAL;
  assign tap_sel = taps[lane_q];
  assign blocked = op_q == OP_UP ? |(at_max & lane_oh) : |(at_min & lane_oh);
  assign oor = |(dl_out_of_range & lane_oh);
  ddr_ca_dly_tap_tracker #(
    .NUM_LANES(NUM_LANES), .TAP_W(TAP_W), .TAP_MAX(TAP_MAX), .TAP_DEFAULT(TAP_DEFAULT)
  ) u_tap (
    .clk(fab_clk), .rst(arst), .sel(lane_oh),
    .inc(state == PULSE && op_q == OP_UP),
    .dec(state == PULSE && op_q == OP_DOWN),
    .load(state == LOAD),
    .tap_value(tap_value), .at_max(at_max), .at_min(at_min)
  );
  // responses and strobes are set on the transition into their state so they are registered
  always_ff @(posedge fab_clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      op_q <= OP_UP;
      lane_q <= '0;
      steps_q <= '0;
      cnt <= '0;
      lane_busy <= '0;
      dl_move <= '0;
      dl_direction <= '0;
      dl_load <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_tap <= '0;
    end else begin
      dl_move <= '0;
      dl_load <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_tap <= '0;
      case (state)
        IDLE: if (req_valid) begin
          lane_q <= req_lane;
          op_q <= op_t'(req_op);
          steps_q <= req_steps;
          if (!legal) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
          end else begin
            lane_busy <= req_oh;
            if (req_op == OP_LOAD) begin
              state <= LOAD;
              dl_load <= req_oh;
            end else if (req_steps == '0) begin
              state <= DONE;
              rsp_valid <= 1'b1;
              rsp_tap <= taps[req_lane];
            end else begin
              state <= SETUP;
              dl_direction <= req_op == OP_UP ? req_oh : '0;
            end
          end
        end
        SETUP: if (blocked) begin
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
          rsp_tap <= tap_sel;
          dl_direction <= '0;
        end else begin
          state <= PULSE;
          dl_move <= lane_oh;
        end
        PULSE: begin
          state <= SETTLE;
          cnt <= CNT_W'(SETTLE_CYCLES - 1);
          steps_q <= steps_q - 1'b1;
        end
        LOAD: begin
          state <= SETTLE;
          cnt <= CNT_W'(SETTLE_CYCLES - 1);
        end
        SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
        else if (oor || op_q == OP_LOAD || steps_q == '0) begin
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_err <= oor;
          rsp_tap <= tap_sel;
          dl_direction <= '0;
        end else state <= SETUP;
        DONE: begin
          state <= IDLE;
          lane_busy <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge fab_clk or posedge arst)
    if (arst) begin
      tx_q <= '1;
      oe_q <= '1;
    end else begin
      tx_q <= fab_tx_data;
      oe_q <= fab_oe_data;
    end
  // the override follows lane_busy directly so the lane returns to live data right after DONE
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_dp
    assign tx_data[4*i +: 4] = lane_busy[i] ? IDLE_PAT : tx_q[4*i +: 4];
    assign oe_data[4*i +: 4] = lane_busy[i] ? IDLE_PAT : oe_q[4*i +: 4];
    assign taps[i] = tap_value[i*TAP_W +: TAP_W];
  end
`ifdef DDR_CA_DLY_STATS_EN
  always_ff @(posedge fab_clk or posedge arst)
    if (arst) err_count <= '0;
    else if (rsp_valid && rsp_err && err_count != '1) err_count <= err_count + 1'b1;
`endif
endmodule

// File: tb/tb_ddr_ca_dly_lane_ctrl.sv
// tb_ddr_ca_dly_lane_ctrl: randomized self-checking bench against a request-level reference model
module tb_ddr_ca_dly_lane_ctrl;
  localparam int N = 8, TW = 7, TMAX = 127, TDEF = 1, S = 4, LW = 3;
  logic fab_clk = 1'b0;
  logic arst = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [LW-1:0] req_lane = '0;
  logic [1:0] req_op = '0;
  logic [TW-1:0] req_steps = '0;
  logic rsp_valid, rsp_err;
  logic [TW-1:0] rsp_tap;
  logic [N-1:0] lane_busy, dl_move, dl_direction, dl_load;
  logic [N-1:0] dl_out_of_range = '0;
  logic [N*TW-1:0] tap_value;
  logic [N*4-1:0] fab_tx_data, fab_oe_data, tx_data, oe_data;
`ifdef DDR_CA_DLY_STATS_EN
  logic [15:0] err_count;
`endif
  int checks = 0;
  int fails = 0;
  int tap_m [N];
  int err_m = 0;
  bit hold_fab = 0;

  ddr_ca_dly_lane_ctrl dut (
    .fab_clk(fab_clk), .arst(arst),
    .req_valid(req_valid), .req_ready(req_ready), .req_lane(req_lane),
    .req_op(req_op), .req_steps(req_steps),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_tap(rsp_tap),
`ifdef DDR_CA_DLY_STATS_EN
    .err_count(err_count),
`endif
    .lane_busy(lane_busy), .tap_value(tap_value),
    .dl_move(dl_move), .dl_direction(dl_direction), .dl_load(dl_load),
    .dl_out_of_range(dl_out_of_range),
    .fab_tx_data(fab_tx_data), .fab_oe_data(fab_oe_data),
    .tx_data(tx_data), .oe_data(oe_data)
  );

  always #5 fab_clk = ~fab_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*TW-1:0] taps_exp();
    logic [N*TW-1:0] v;
    for (int i = 0; i < N; i++) v[i*TW +: TW] = TW'(tap_m[i]);
    return v;
  endfunction

  // model: walk the request step by step with plain tap arithmetic to get latency, error and final tap
  task automatic do_req(input int lane, input int op, input int steps, input int oor_k);
    int t, n, lat, err, exp_tap, period;
    bit legal, up;
    logic [N-1:0] oh, busy, mv;
    logic [N*4-1:0] etx, eoe;
    period = 2 + S;
    legal = op != 3;
    up = op == 0;
    t = tap_m[lane];
    n = 0;
    err = 0;
    lat = 1;
    exp_tap = 0;
    if (!legal) err = 1;
    else if (op == 2) begin
      lat = S + 2;
      t = TDEF;
      exp_tap = t;
    end else begin
      for (int k = 0; k < steps; k++) begin
        if ((up && t == TMAX) || (!up && t == 0)) begin
          err = 1;
          lat++;
          break;
        end
        t += up ? 1 : -1;
        n++;
        lat += period;
        if (k == oor_k) begin
          err = 1;
          break;
        end
      end
      exp_tap = t;
    end
    if (legal) tap_m[lane] = t;
    if (err != 0 && err_m < 65535) err_m++;
    oh = legal ? N'(1) << lane : '0;
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_lane = LW'(lane);
    req_op = 2'(op);
    req_steps = TW'(steps);
    for (int off = 1; off <= lat + 1; off++) begin
      @(posedge fab_clk);
      #1;
      req_valid = 1'b0;
      busy = off <= lat ? oh : '0;
      etx = fab_tx_data;
      eoe = fab_oe_data;
      for (int i = 0; i < N; i++)
        if (busy[i]) begin
          etx[4*i +: 4] = 4'hf;
          eoe[4*i +: 4] = 4'hf;
        end
      chk("tx_data", tx_data, etx);
      chk("oe_data", oe_data, eoe);
      chk("lane_busy", lane_busy, busy);
      chk("req_ready", req_ready, off > lat);
      chk("rsp_valid", rsp_valid, off == lat);
      if (off == lat) begin
        chk("rsp_err", rsp_err, err);
        chk("rsp_tap", rsp_tap, exp_tap);
        chk("tap_value", tap_value, taps_exp());
      end
      mv = (op < 2 && off >= 2 && (off - 2) % period == 0 && (off - 2) / period < n) ? oh : '0;
      chk("dl_move", dl_move, mv);
      chk("dl_load", dl_load, (op == 2 && off == 1) ? oh : '0);
      chk("dl_direction", dl_direction, (op == 0 && off < lat) ? oh : '0);
`ifdef DDR_CA_DLY_STATS_EN
      if (off == lat + 1) chk("err_count", err_count, err_m);
`endif
      if (oor_k >= 0 && off == 2 + oor_k * period) dl_out_of_range[lane] = 1'b1;
      if (off == lat) dl_out_of_range = '0;
      if (!hold_fab) begin
        fab_tx_data = $urandom();
        fab_oe_data = $urandom();
      end
    end
  endtask

  initial begin
    int lane, op, steps, oor_k, r;
    for (int i = 0; i < N; i++) tap_m[i] = TDEF;
    fab_tx_data = $urandom();
    fab_oe_data = $urandom();
    #2 arst = 1'b1;
    repeat (3) @(posedge fab_clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_tap", rsp_tap, 0);
    chk("rst_busy", lane_busy, 0);
    chk("rst_dl", {dl_move, dl_direction, dl_load}, 0);
    chk("rst_taps", tap_value, taps_exp());
    chk("rst_tx", tx_data, 32'hffff_ffff);
    chk("rst_oe", oe_data, 32'hffff_ffff);
`ifdef DDR_CA_DLY_STATS_EN
    chk("rst_err_count", err_count, 0);
`endif
    arst = 1'b0;
    @(posedge fab_clk);
    #1;
    do_req(2, 0, 3, -1);
    do_req(5, 1, 1, -1);
    do_req(5, 1, 2, -1);
    do_req(0, 0, TMAX - 1 - TDEF, -1);
    do_req(0, 0, 5, -1);
    do_req(3, 0, 2, 0);
    fab_tx_data[7:4] = 4'b0101;
    fab_tx_data[19:16] = 4'b0011;
    hold_fab = 1;
    do_req(1, 2, 0, -1);
    hold_fab = 0;
    do_req(4, 3, 2, -1);
    do_req(7, 1, 0, -1);
    do_req(6, 2, 9, -1);
    for (int j = 0; j < 40; j++) begin
      lane = $urandom_range(0, N - 1);
      r = $urandom_range(0, 9);
      op = r < 4 ? 0 : r < 8 ? 1 : r < 9 ? 2 : 3;
      steps = $urandom_range(0, 6);
      oor_k = -1;
      if (op < 2 && steps > 0 && $urandom_range(0, 4) == 0) oor_k = $urandom_range(0, steps - 1);
      do_req(lane, op, steps, oor_k);
    end
    req_valid = 1'b1;
    req_lane = 3'd6;
    req_op = 2'b00;
    req_steps = 7'd3;
    @(posedge fab_clk);
    #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge fab_clk);
      #1;
    end
    arst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) tap_m[i] = TDEF;
    err_m = 0;
    chk("arst_dl", {dl_move, dl_direction, dl_load}, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_busy", lane_busy, 0);
    chk("arst_tap6", tap_value[6*TW +: TW], TDEF);
    chk("arst_taps", tap_value, taps_exp());
    chk("arst_tx", tx_data, 32'hffff_ffff);
`ifdef DDR_CA_DLY_STATS_EN
    chk("arst_err_count", err_count, 0);
`endif
    @(posedge fab_clk);
    #1;
    arst = 1'b0;
    repeat (20) begin
      @(posedge fab_clk);
      #1;
      chk("no_rsp_after_arst", rsp_valid, 0);
    end
    do_req(2, 3, 1, -1);
    do_req(6, 1, 3, -1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
